// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, field positions, decoded-instruction
// struct and a register-busy helper used by the hazard logic.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RAW     = 5;
  localparam int unsigned NREG    = 32;
  localparam int unsigned OPW     = 6;
  localparam int unsigned FUNW    = 6;
  localparam int unsigned IMMW    = 16;
  localparam int unsigned STALLW  = 16;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_J     = 6'h02;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [FUNW-1:0] funct;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  dest;
    logic            wen;
    logic            uses_rs;
    logic            uses_rt;
    logic [XLEN-1:0] imm;
  } decoded_t;

  // Register r is busy if it is pending or is the destination of the held instruction; r0 never is.
  function automatic logic reg_busy(input logic [RAW-1:0]  r,
                                    input logic [NREG-1:0] pend,
                                    input logic            held_wen,
                                    input logic [RAW-1:0]  held_dest);
    return (r != '0) && (pend[r] || (held_wen && (held_dest == r)));
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational MIPS decoder: instruction word to decoded fields and read/write usage.
module instr_decode
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output decoded_t        dec_o
);

  // Field extraction and per-opcode source/destination usage
  always_comb begin
    dec_o         = '0;
    dec_o.op      = instr_i[OP_LSB +: OPW];
    dec_o.funct   = instr_i[FUNCT_LSB +: FUNW];
    dec_o.rs      = instr_i[RS_LSB +: RAW];
    dec_o.rt      = instr_i[RT_LSB +: RAW];
    dec_o.imm     = {{(XLEN-IMMW){instr_i[IMM_LSB+IMMW-1]}}, instr_i[IMM_LSB +: IMMW]};
    case (dec_o.op)
      OP_RTYPE: begin
        dec_o.uses_rs = 1'b1;
        dec_o.uses_rt = 1'b1;
        dec_o.dest    = instr_i[RD_LSB +: RAW];
        dec_o.wen     = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        dec_o.uses_rs = 1'b1;
        dec_o.uses_rt = 1'b1;
      end
      OP_J: begin
      end
      default: begin
        dec_o.uses_rs = 1'b1;
        dec_o.dest    = instr_i[RT_LSB +: RAW];
        dec_o.wen     = 1'b1;
      end
    endcase
    // Writes to r0 are discarded, so they never occupy the scoreboard
    if (dec_o.dest == '0) dec_o.wen = 1'b0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-read stage: scoreboarded hazard stall, single output register.
// Build option: define OPERAND_FWD_EN to bypass the retiring writeback value
// into the operands in the same cycle (zero-bubble retire-to-issue).
module operand_fetch
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rstd,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [RAW-1:0]    rf_raddr1,
  output logic [RAW-1:0]    rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_valid,
  input  logic [RAW-1:0]    wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [OPW-1:0]    out_op,
  output logic [FUNW-1:0]   out_funct,
  output logic [RAW-1:0]    out_dest,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_opa,
  output logic [XLEN-1:0]   out_opb,
  output logic [XLEN-1:0]   out_imm,
  output logic [STALLW-1:0] stall_cycles
);

  decoded_t          dec;
  logic [NREG-1:0]   pending_q, pending_d, pending_eff;
  logic              out_valid_q, out_wen_q;
  logic [XLEN-1:0]   out_pc_q, out_opa_q, out_opb_q, out_imm_q;
  logic [OPW-1:0]    out_op_q;
  logic [FUNW-1:0]   out_funct_q;
  logic [RAW-1:0]    out_dest_q;
  logic [STALLW-1:0] stall_q;
  logic              held_wen, hazard, slot_free, accept, handoff, stall_inc;
  logic              fwd_a, fwd_b;
  logic [XLEN-1:0]   opa_d, opb_d;

  instr_decode u_decode (
    .instr_i (in_instr),
    .dec_o   (dec)
  );

  assign rf_raddr1 = dec.rs;
  assign rf_raddr2 = dec.rt;

`ifdef OPERAND_FWD_EN
  // A register retiring this cycle is readable now through the bypass
  assign pending_eff = pending_q & ~(wb_valid ? (NREG'(1) << wb_addr) : '0);
  assign fwd_a       = wb_valid && (wb_addr == dec.rs) && (dec.rs != '0);
  assign fwd_b       = wb_valid && (wb_addr == dec.rt) && (dec.rt != '0);
`else
  // Without the bypass the retired value is visible only after the RF write edge
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign pending_eff    = pending_q;
  assign fwd_a          = 1'b0;
  assign fwd_b          = 1'b0;
`endif

  assign held_wen  = out_valid_q && out_wen_q;
  assign hazard    = (dec.uses_rs && reg_busy(dec.rs,   pending_eff, held_wen, out_dest_q))
                  || (dec.uses_rt && reg_busy(dec.rt,   pending_eff, held_wen, out_dest_q))
                  || (dec.wen     && reg_busy(dec.dest, pending_eff, held_wen, out_dest_q));
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !rstd && !flush && !hazard && slot_free;
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid_q && out_ready && !flush;
  assign stall_inc = in_valid && hazard && slot_free && !flush;

  assign opa_d = dec.uses_rs ? (fwd_a ? wb_data : rf_rdata1) : '0;
  assign opb_d = dec.uses_rt ? (fwd_b ? wb_data : rf_rdata2) : dec.imm;

  // Scoreboard next state: retire clears, handoff sets, set wins on collision
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_addr] = 1'b0;
    if (handoff && out_wen_q) pending_d[out_dest_q] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rstd) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // Output pipeline register: load on accept, drop on flush or handoff
  always_ff @(posedge clk) begin
    if (rstd) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_op_q    <= '0;
      out_funct_q <= '0;
      out_dest_q  <= '0;
      out_wen_q   <= 1'b0;
      out_opa_q   <= '0;
      out_opb_q   <= '0;
      out_imm_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= in_pc;
      out_op_q    <= dec.op;
      out_funct_q <= dec.funct;
      out_dest_q  <= dec.dest;
      out_wen_q   <= dec.wen;
      out_opa_q   <= opa_d;
      out_opb_q   <= opb_d;
      out_imm_q   <= dec.imm;
    end else if (flush || out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating hazard stall counter
  always_ff @(posedge clk) begin
    if (rstd)                                stall_q <= '0;
    else if (stall_inc && (stall_q != '1))   stall_q <= stall_q + STALLW'(1);
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_op       = out_op_q;
  assign out_funct    = out_funct_q;
  assign out_dest     = out_dest_q;
  assign out_wen      = out_wen_q;
  assign out_opa      = out_opa_q;
  assign out_opb      = out_opb_q;
  assign out_imm      = out_imm_q;
  assign stall_cycles = stall_q;

endmodule
